// File: rtl/hc8_bus_ctrl.sv
// hc8_bus_ctrl: memory/peripheral target on the HC8 core address/data bus.
//
// Provides a 256-byte data RAM, a UART transmitter (8N1, LSB first) fed by a
// TX FIFO, and 8-bit GPIO output/input ports. Reads are combinational; writes
// commit on the posedge ending the mem_wr cycle.
//
// Ports:
//   clk          system clock, all state updates on posedge
//   Reset        synchronous active-high reset
//   address_bus  16-bit byte address from the core
//   bus_wdata    write data (core-driven data_bus)
//   mem_wr       write request, level-valid for the whole cycle
//   mem_rd       read request, level-valid for the whole cycle
//   bus_rdata    read data, 0x00 when mem_rd is low
//   bus_oe       data_bus drive enable for the top level (equals mem_rd)
//   gpio_out     GPIO output register
//   gpio_in      asynchronous GPIO inputs
//   uart_tx      serial TX line, idle high
//
// Address map: 0x0000-0x00FF RAM, 0xFF00 TX data, 0xFF01 status,
//              0xFF02 GPIO out, 0xFF03 GPIO in. Everything else reads 0x00.

module hc8_bus_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [15:0] address_bus,
    input  logic [7:0]  bus_wdata,
    input  logic        mem_wr,
    input  logic        mem_rd,
    output logic [7:0]  bus_rdata,
    output logic        bus_oe,
    output logic [7:0]  gpio_out,
    input  logic [7:0]  gpio_in,
    output logic        uart_tx
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    // Address decode
    logic sel_ram, sel_txd, sel_stat, sel_gpo, sel_gpi;
    assign sel_ram  = (address_bus[15:8] == 8'h00);
    assign sel_txd  = (address_bus == 16'hFF00);
    assign sel_stat = (address_bus == 16'hFF01);
    assign sel_gpo  = (address_bus == 16'hFF02);
    assign sel_gpi  = (address_bus == 16'hFF03);

    // Storage
    logic [7:0] ram_mem  [256];
    logic [7:0] fifo_mem [FIFO_DEPTH];

    // State
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       gpio_out_q, gpio_out_d;
    logic [7:0]       sync1_q, sync1_d;
    logic [7:0]       sync2_q, sync2_d;
    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             uart_tx_q, uart_tx_d;

    logic wr_txd, fifo_full, fifo_empty, push, pop, tx_busy, bit_end;

    assign wr_txd     = mem_wr && sel_txd;
    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == '0);
    assign push       = wr_txd && !fifo_full;
    assign pop        = (state_q == ST_IDLE) && !fifo_empty;
    assign tx_busy    = (state_q != ST_IDLE);
    assign bit_end    = (clk_cnt_q == BIT_LAST);

    // Register, FIFO and GPIO next-state
    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;

        // A dropped push sets overflow; the set takes priority over a clear
        // arriving in the same cycle.
        overflow_d = overflow_q;
        if (wr_txd && fifo_full)
            overflow_d = 1'b1;
        else if (mem_wr && sel_stat)
            overflow_d = 1'b0;

        gpio_out_d = (mem_wr && sel_gpo) ? bus_wdata : gpio_out_q;
        sync1_d    = gpio_in;
        sync2_d    = sync1_q;
    end

    // TX framing next-state
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d   = ST_START;
                    clk_cnt_d = '0;
                    shift_d   = fifo_mem[rd_ptr_q];
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    shift_d   = shift_q >> 1;
                    if (bit_idx_q == 3'd7)
                        state_d = ST_STOP;
                    else
                        bit_idx_d = bit_idx_q + 1'b1;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_d   = ST_IDLE;
                    clk_cnt_d = '0;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The line level is registered from the next state, so uart_tx always
        // matches the state it is shown in and is glitch-free.
        uart_tx_d = 1'b1;
        if (state_d == ST_START)
            uart_tx_d = 1'b0;
        else if (state_d == ST_DATA)
            uart_tx_d = shift_d[0];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of order.
    always_ff @(posedge clk) begin
        if (Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            gpio_out_q <= 8'h00;
            sync1_q    <= 8'h00;
            sync2_q    <= 8'h00;
            state_q    <= ST_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= 8'h00;
            uart_tx_q  <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            gpio_out_q <= gpio_out_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            uart_tx_q  <= uart_tx_d;
        end
    end

    // NOTE: RAM and FIFO storage carry no reset; the FIFO pointers and count
    // define what is valid, and RAM contents survive reset by design.
    always_ff @(posedge clk) begin
        if (mem_wr && sel_ram)
            ram_mem[address_bus[7:0]] <= bus_wdata;
        if (push)
            fifo_mem[wr_ptr_q] <= bus_wdata;
    end

    // Combinational read path. A simultaneous write returns the pre-write value.
    // NOTE: bus_rdata gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        bus_rdata = 8'h00;
        if (mem_rd) begin
            if (sel_ram)
                bus_rdata = ram_mem[address_bus[7:0]];
            else if (sel_stat)
                bus_rdata = {4'h0, overflow_q, tx_busy, fifo_full, fifo_empty};
            else if (sel_gpo)
                bus_rdata = gpio_out_q;
            else if (sel_gpi)
                bus_rdata = sync2_q;
        end
    end

    assign bus_oe   = mem_rd;
    assign gpio_out = gpio_out_q;
    assign uart_tx  = uart_tx_q;

endmodule

// File: tb/tb_hc8_bus_ctrl.sv
// Self-checking bench for hc8_bus_ctrl. A behavioural model tracks RAM, GPIO,
// the queued TX bytes and the expected serial waveform as a queue of line
// samples; a compare process checks the DUT against it every cycle, and the
// directed sequence pins the model with hand-computed literals. A small UART
// receiver decodes the line so transmitted byte order is checked end to end.

module tb_hc8_bus_ctrl;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] address_bus = 16'h0000;
    logic [7:0]  bus_wdata = 8'h00;
    logic        mem_wr = 1'b0;
    logic        mem_rd = 1'b0;
    logic [7:0]  bus_rdata;
    logic        bus_oe;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_in = 8'h81;
    logic        uart_tx;

    always #5 clk = ~clk;

    hc8_bus_ctrl #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .address_bus(address_bus),
        .bus_wdata  (bus_wdata),
        .mem_wr     (mem_wr),
        .mem_rd     (mem_rd),
        .bus_rdata  (bus_rdata),
        .bus_oe     (bus_oe),
        .gpio_out   (gpio_out),
        .gpio_in    (gpio_in),
        .uart_tx    (uart_tx)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_ram [256];
    bit         m_ram_ok [256];
    logic [7:0] m_fifo [$];
    bit         m_line [$];      // remaining line samples of the frame in flight
    bit         m_ovf = 1'b0;
    logic [7:0] m_gpio_out = 8'h00;
    logic [7:0] m_h1 = 8'h00, m_h2 = 8'h00;
    bit         model_ready = 1'b0;

    always @(posedge clk) begin : model_step
        int unsigned cnt;
        bit          was_idle;
        bit          ovf_set, ovf_clr;
        logic [7:0]  b;
        cnt      = m_fifo.size();
        was_idle = (m_line.size() == 0);
        ovf_set  = 1'b0;
        ovf_clr  = 1'b0;
        if (mem_wr && address_bus < 16'h0100) begin
            m_ram[address_bus[7:0]]    = bus_wdata;
            m_ram_ok[address_bus[7:0]] = 1'b1;
        end
        if (Reset) begin
            m_fifo.delete();
            m_line.delete();
            m_ovf       = 1'b0;
            m_gpio_out  = 8'h00;
            m_h1        = 8'h00;
            m_h2        = 8'h00;
            model_ready = 1'b1;
        end else begin
            if (mem_wr) begin
                case (address_bus)
                    16'hFF00: if (cnt < DEPTH) m_fifo.push_back(bus_wdata); else ovf_set = 1'b1;
                    16'hFF01: ovf_clr = 1'b1;
                    16'hFF02: m_gpio_out = bus_wdata;
                    default: ;
                endcase
            end
            if (ovf_set)      m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            if (!was_idle) begin
                void'(m_line.pop_front());
            end else if (cnt != 0) begin
                b = m_fifo.pop_front();
                for (int k = 0; k < 10; k++) begin
                    bit lvl;
                    lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
                    for (int j = 0; j < CPB; j++) m_line.push_back(lvl);
                end
            end
            m_h2 = m_h1;
            m_h1 = gpio_in;
        end
    end

    function automatic void model_read(input logic [15:0] a, output logic [7:0] v, output bit known);
        known = 1'b1;
        v     = 8'h00;
        if (a < 16'h0100) begin
            known = m_ram_ok[a[7:0]];
            v     = m_ram[a[7:0]];
        end else if (a == 16'hFF01) begin
            v = {4'h0, m_ovf, m_line.size() != 0, m_fifo.size() == DEPTH, m_fifo.size() == 0};
        end else if (a == 16'hFF02) begin
            v = m_gpio_out;
        end else if (a == 16'hFF03) begin
            v = m_h2;
        end
    endfunction

    // Compare process: mid-low-phase, after inputs settle, away from posedge.
    always @(negedge clk) begin
        logic [7:0] exp_rd;
        bit         known;
        #2;
        if (model_ready) begin
            check("uart_tx", 8'(uart_tx), 8'((m_line.size() == 0) ? 1'b1 : m_line[0]));
            check("gpio_out", gpio_out, m_gpio_out);
            check("bus_oe", 8'(bus_oe), 8'(mem_rd));
            if (mem_rd) begin
                model_read(address_bus, exp_rd, known);
                if (known) check("bus_rdata", bus_rdata, exp_rd);
            end else begin
                check("bus_rdata_idle", bus_rdata, 8'h00);
            end
        end
    end

    // ---------------- line receiver ----------------
    logic [7:0] rx_bytes [$];
    bit         rx_active = 1'b0;
    int         rx_idx = 0;
    logic [7:0] rx_byte = 8'h00;

    always @(negedge clk) begin
        #2;
        if (Reset) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (uart_tx === 1'b0) begin
                rx_active = 1'b1;
                rx_idx    = 1;
            end
        end else begin
            if (rx_idx >= CPB && rx_idx < 9 * CPB && (rx_idx % CPB) == CPB / 2)
                rx_byte[rx_idx / CPB - 1] = uart_tx;
            if (rx_idx == 9 * CPB + CPB / 2) begin
                rx_bytes.push_back(rx_byte);
                rx_active = 1'b0;
            end
            rx_idx++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic wr, input logic rd, input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        address_bus = a;
        bus_wdata   = d;
        mem_wr      = wr;
        mem_rd      = rd;
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    logic [7:0] tx_data [10];
    bit         pat [10];

    initial begin : main
        tx_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
        pat     = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        Reset = 1'b0;

        // Reset state
        drive(1'b0, 1'b1, 16'hFF01, 8'h00);
        check("rst_status", bus_rdata, 8'h01);
        check("rst_uart_tx", 8'(uart_tx), 8'h01);
        check("rst_gpio_out", gpio_out, 8'h00);

        // RAM / decode / GPIO out
        drive(1'b1, 1'b0, 16'h0010, 8'h5A);
        drive(1'b0, 1'b1, 16'h0010, 8'h00);
        check("ram_rd_0010", bus_rdata, 8'h5A);
        drive(1'b0, 1'b1, 16'h1234, 8'h00);
        check("unmapped_rd", bus_rdata, 8'h00);
        drive(1'b1, 1'b0, 16'hFF02, 8'hA5);
        drive(1'b0, 1'b1, 16'hFF02, 8'h00);
        check("gpio_out_pin", gpio_out, 8'hA5);
        check("gpio_out_rd", bus_rdata, 8'hA5);
        drive(1'b1, 1'b1, 16'h0010, 8'h77);
        check("rw_same_cycle", bus_rdata, 8'h5A);
        drive(1'b0, 1'b1, 16'h0010, 8'h00);
        check("ram_after_rw", bus_rdata, 8'h77);
        drive(1'b1, 1'b0, 16'hFF03, 8'hEE);
        drive(1'b0, 1'b1, 16'hFF00, 8'h00);
        check("txd_rd_zero", bus_rdata, 8'h00);
        drive(1'b0, 1'b0, 16'h0010, 8'h00);
        check("rd_low_zero", bus_rdata, 8'h00);
        check("oe_low", 8'(bus_oe), 8'h00);

        // Single frame 0x41
        drive(1'b1, 1'b0, 16'hFF00, 8'h41);
        drive(1'b0, 1'b1, 16'hFF01, 8'h00);
        check("pre_start_uart", 8'(uart_tx), 8'h01);
        check("pre_start_status", bus_rdata, 8'h00);
        for (int k = 0; k < 10 * CPB; k++) begin
            drive(1'b0, 1'b1, 16'hFF01, 8'h00);
            check("frame41_bit", 8'(uart_tx), 8'(pat[k / CPB]));
            check("frame41_status", bus_rdata, 8'h05);
        end
        drive(1'b0, 1'b1, 16'hFF01, 8'h00);
        check("frame41_done_status", bus_rdata, 8'h01);
        check("frame41_done_uart", 8'(uart_tx), 8'h01);
        idle(2);
        rx_bytes.delete();

        // Ten back-to-back writes: nine accepted, tenth overflows
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 16'hFF00, tx_data[i]);
        drive(1'b0, 1'b1, 16'hFF01, 8'h00);
        check("full_ovf_status", bus_rdata, 8'h0E);
        drive(1'b1, 1'b0, 16'hFF01, 8'h00);
        drive(1'b0, 1'b1, 16'hFF01, 8'h00);
        check("ovf_cleared_status", bus_rdata, 8'h06);
        for (int c = 0; c < 800 && rx_bytes.size() < 9; c++) idle(1);
        check("rx_count", 8'(rx_bytes.size()), 8'd9);
        for (int i = 0; i < 9; i++)
            if (i < rx_bytes.size()) check("rx_order", rx_bytes[i], tx_data[i]);
        idle(4);
        drive(1'b0, 1'b1, 16'hFF01, 8'h00);
        check("drained_status", bus_rdata, 8'h01);

        // Reset during data bit 3 of a frame
        rx_bytes.delete();
        drive(1'b1, 1'b0, 16'hFF00, 8'hC3);
        drive(1'b1, 1'b0, 16'hFF00, 8'h5A);
        drive(1'b1, 1'b0, 16'hFF00, 8'h99);
        idle(16);
        check("bit3_low", 8'(uart_tx), 8'h00);
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        Reset       = 1'b0;
        address_bus = 16'hFF01;
        mem_rd      = 1'b1;
        #2;
        check("abort_uart", 8'(uart_tx), 8'h01);
        check("abort_status", bus_rdata, 8'h01);
        idle(100);
        check("abort_no_frames", 8'(rx_bytes.size()), 8'd0);
        drive(1'b0, 1'b1, 16'hFF01, 8'h00);
        check("abort_status_late", bus_rdata, 8'h01);

        // GPIO input synchroniser latency
        @(negedge clk);
        gpio_in     = 8'h3C;
        address_bus = 16'hFF03;
        mem_rd      = 1'b1;
        mem_wr      = 1'b0;
        #2;
        check("gpi_edge0", bus_rdata, 8'h81);
        @(negedge clk);
        #2;
        check("gpi_edge1", bus_rdata, 8'h81);
        @(negedge clk);
        #2;
        check("gpi_edge2", bus_rdata, 8'h3C);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
